// File: rtl/ucsbece154b_branch_resolve_if.sv
// Bundle between the fetch/decode/execute pipeline and the branch resolve stage.
// The resolve stage is the slave; the pipeline (or a bench) is the master.
interface ucsbece154b_branch_resolve_if #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
);
  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

  // Fetch-side prediction
  logic [31:0]             pc_f_i;
  logic                    BranchTaken_f_i;
  logic [31:0]             BTBtarget_f_i;
  logic [NUM_GHR_BITS-1:0] PHTreadaddress_f_i;

  // Hazard controls and later-stage information
  logic                    StallF_i;
  logic                    StallD_i;
  logic                    FlushE_i;
  logic [6:0]              op_d_i;
  logic                    BranchActual_e_i;
  logic [31:0]             Target_e_i;

  // Redirect and predictor update
  logic [31:0]             PCnext_f_o;
  logic                    Mispredict_e_o;
  logic                    BTB_we_o;
  logic [BTB_IDX_W-1:0]    BTBwriteaddress_o;
  logic [31:0]             BTBwritedata_o;
  logic                    PHTwe_o;
  logic                    PHTincrement_o;
  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
  logic                    GHRreset_o;
  logic [31:0]             BranchCount_o;
  logic [31:0]             MispredictCount_o;

  modport master (
    output pc_f_i, BranchTaken_f_i, BTBtarget_f_i, PHTreadaddress_f_i,
    output StallF_i, StallD_i, FlushE_i, op_d_i, BranchActual_e_i, Target_e_i,
    input  PCnext_f_o, Mispredict_e_o, BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
    input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
    input  BranchCount_o, MispredictCount_o
  );

  modport slave (
    input  pc_f_i, BranchTaken_f_i, BTBtarget_f_i, PHTreadaddress_f_i,
    input  StallF_i, StallD_i, FlushE_i, op_d_i, BranchActual_e_i, Target_e_i,
    output PCnext_f_o, Mispredict_e_o, BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
    output PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
    output BranchCount_o, MispredictCount_o
  );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// Branch resolve stage: picks the next fetch PC, carries each fetch prediction
// through D and E, resolves it in Execute, and drives predictor updates,
// the mispredict redirect and the performance counters.
module ucsbece154b_branch_resolve #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic clk,
  input  logic reset_i,
  ucsbece154b_branch_resolve_if.slave bus
);
  localparam int         BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // D register
  logic                    d_vld_q, d_vld_d;
  logic [31:0]             d_pc_q, d_pc_d;
  logic                    d_pred_taken_q, d_pred_taken_d;
  logic [31:0]             d_pred_target_q, d_pred_target_d;
  logic [NUM_GHR_BITS-1:0] d_pht_addr_q, d_pht_addr_d;

  // E register
  logic                    e_vld_q, e_vld_d;
  logic [31:0]             e_pc_q, e_pc_d;
  logic                    e_pred_taken_q, e_pred_taken_d;
  logic [31:0]             e_pred_target_q, e_pred_target_d;
  logic [NUM_GHR_BITS-1:0] e_pht_addr_q, e_pht_addr_d;
  logic [6:0]              e_op_q, e_op_d;

  // Control and counters
  logic                    ghr_reset_q, ghr_reset_d;
  logic [31:0]             branch_cnt_q, branch_cnt_d;
  logic [31:0]             mispred_cnt_q, mispred_cnt_d;

  // Execute-stage resolution
  logic                    is_br, is_j, ctl;
  logic                    target_diff;
  logic                    mispredict;
  logic                    pht_we;
  logic [31:0]             redirect_pc;

  // Resolve the prediction held in E against the actual outcome
  always_comb begin
    is_br       = (e_op_q == OP_BRANCH);
    is_j        = (e_op_q == OP_JAL) || (e_op_q == OP_JALR);
    ctl         = e_vld_q && (is_br || is_j);
    target_diff = (e_pred_target_q != bus.Target_e_i);
    // A not-taken branch predicted not-taken never mispredicts, whatever its target.
    mispredict  = ctl && ((bus.BranchActual_e_i != e_pred_taken_q) ||
                          (bus.BranchActual_e_i && target_diff));
    pht_we      = e_vld_q && is_br;
    redirect_pc = bus.BranchActual_e_i ? bus.Target_e_i : (e_pc_q + 32'd4);
  end

  // Drive redirect, next fetch PC and predictor updates; bubbles stay silent
  always_comb begin
    bus.Mispredict_e_o    = mispredict;
    bus.PCnext_f_o        = mispredict ? redirect_pc :
                            (bus.BranchTaken_f_i ? bus.BTBtarget_f_i : (bus.pc_f_i + 32'd4));
    bus.PHTwe_o           = pht_we;
    bus.PHTincrement_o    = e_vld_q && bus.BranchActual_e_i;
    bus.PHTwriteaddress_o = e_vld_q ? e_pht_addr_q : '0;
    bus.BTB_we_o          = ctl && bus.BranchActual_e_i && (!e_pred_taken_q || target_diff);
    bus.BTBwriteaddress_o = e_vld_q ? e_pc_q[BTB_IDX_W+1:2] : '0;
    bus.BTBwritedata_o    = e_vld_q ? bus.Target_e_i : 32'd0;
    bus.GHRreset_o        = ghr_reset_q;
    bus.BranchCount_o     = branch_cnt_q;
    bus.MispredictCount_o = mispred_cnt_q;
  end

  // D register next state: squash on mispredict, hold on stall, else take fetch
  always_comb begin
    d_vld_d         = d_vld_q;
    d_pc_d          = d_pc_q;
    d_pred_taken_d  = d_pred_taken_q;
    d_pred_target_d = d_pred_target_q;
    d_pht_addr_d    = d_pht_addr_q;
    if (mispredict) begin
      d_vld_d = 1'b0;
    end else if (!bus.StallD_i) begin
      d_vld_d         = 1'b1;
      d_pc_d          = bus.pc_f_i;
      d_pred_taken_d  = bus.BranchTaken_f_i;
      d_pred_target_d = bus.BTBtarget_f_i;
      d_pht_addr_d    = bus.PHTreadaddress_f_i;
    end
  end

  // E register next state: bubble on mispredict, flush or D stall, else take D
  always_comb begin
    e_vld_d         = e_vld_q;
    e_pc_d          = e_pc_q;
    e_pred_taken_d  = e_pred_taken_q;
    e_pred_target_d = e_pred_target_q;
    e_pht_addr_d    = e_pht_addr_q;
    e_op_d          = e_op_q;
    if (mispredict || bus.FlushE_i || bus.StallD_i) begin
      e_vld_d = 1'b0;
    end else begin
      e_vld_d         = d_vld_q;
      e_pc_d          = d_pc_q;
      e_pred_taken_d  = d_pred_taken_q;
      e_pred_target_d = d_pred_target_q;
      e_pht_addr_d    = d_pht_addr_q;
      e_op_d          = bus.op_d_i;
    end
  end

  // GHR clear pulse and performance counters (counting frozen while fetch stalls)
  always_comb begin
    ghr_reset_d   = 1'b0;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (!bus.StallF_i) begin
      if (pht_we)     branch_cnt_d  = branch_cnt_q + 32'd1;
      if (mispredict) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      d_vld_q         <= 1'b0;
      d_pc_q          <= 32'd0;
      d_pred_taken_q  <= 1'b0;
      d_pred_target_q <= 32'd0;
      d_pht_addr_q    <= '0;
      e_vld_q         <= 1'b0;
      e_pc_q          <= 32'd0;
      e_pred_taken_q  <= 1'b0;
      e_pred_target_q <= 32'd0;
      e_pht_addr_q    <= '0;
      e_op_q          <= 7'd0;
      ghr_reset_q     <= 1'b1;
      branch_cnt_q    <= 32'd0;
      mispred_cnt_q   <= 32'd0;
    end else begin
      d_vld_q         <= d_vld_d;
      d_pc_q          <= d_pc_d;
      d_pred_taken_q  <= d_pred_taken_d;
      d_pred_target_q <= d_pred_target_d;
      d_pht_addr_q    <= d_pht_addr_d;
      e_vld_q         <= e_vld_d;
      e_pc_q          <= e_pc_d;
      e_pred_taken_q  <= e_pred_taken_d;
      e_pred_target_q <= e_pred_target_d;
      e_pht_addr_q    <= e_pht_addr_d;
      e_op_q          <= e_op_d;
      ghr_reset_q     <= ghr_reset_d;
      branch_cnt_q    <= branch_cnt_d;
      mispred_cnt_q   <= mispred_cnt_d;
    end
  end
endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Scenario bench for ucsbece154b_branch_resolve: each task issues instructions
// into fetch, pushes the hand-derived Execute-stage result to a scoreboard and
// pops/compares it when the instruction reaches Execute.
module tb_ucsbece154b_branch_resolve;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_NOP  = 7'b0010011;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic [4:0]  pht;
    logic [6:0]  op;
    logic        act;
    logic [31:0] tgt;
  } ins_t;

  typedef struct {
    logic        mis;
    logic [31:0] redir;
    logic        btb_we;
    logic [4:0]  btb_addr;
    logic [31:0] btb_data;
    logic        pht_we;
    logic        pht_inc;
    logic [4:0]  pht_addr;
  } exp_t;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset_i = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   exp_bcnt = 0;
  int   exp_mcnt = 0;
  exp_t sb[$];

  ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) bus ();

  ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic ins_t mk_ins(logic [31:0] pc, logic pt, logic [31:0] ptgt, logic [4:0] pht,
                                  logic [6:0] op, logic act, logic [31:0] tgt);
    ins_t i;
    i.pc = pc; i.pt = pt; i.ptgt = ptgt; i.pht = pht; i.op = op; i.act = act; i.tgt = tgt;
    return i;
  endfunction

  function automatic exp_t mk_exp(logic mis, logic [31:0] redir, logic btb_we, logic [4:0] btb_addr,
                                  logic [31:0] btb_data, logic pht_we, logic pht_inc, logic [4:0] pht_addr);
    exp_t e;
    e.mis = mis; e.redir = redir; e.btb_we = btb_we; e.btb_addr = btb_addr;
    e.btb_data = btb_data; e.pht_we = pht_we; e.pht_inc = pht_inc; e.pht_addr = pht_addr;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_f(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic [4:0] pht);
    bus.pc_f_i             = pc;
    bus.BranchTaken_f_i    = taken;
    bus.BTBtarget_f_i      = tgt;
    bus.PHTreadaddress_f_i = pht;
  endtask

  // Pops the next expectation and compares every E-stage output against it.
  task automatic check_e(input string tag, input logic [31:0] fpc_next);
    exp_t g;
    logic [31:0] want_pc;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      g = sb.pop_front();
      want_pc = g.mis ? g.redir : fpc_next;
      if (bus.Mispredict_e_o !== g.mis) begin bad++; $display("FAIL %s mispredict got=%0b want=%0b", tag, bus.Mispredict_e_o, g.mis); end
      total++;
      if (bus.PCnext_f_o !== want_pc) begin bad++; $display("FAIL %s pcnext got=%h want=%h", tag, bus.PCnext_f_o, want_pc); end
      total++;
      if (bus.BTB_we_o !== g.btb_we) begin bad++; $display("FAIL %s btb_we got=%0b want=%0b", tag, bus.BTB_we_o, g.btb_we); end
      total++;
      if (bus.BTBwriteaddress_o !== g.btb_addr) begin bad++; $display("FAIL %s btb_addr got=%0d want=%0d", tag, bus.BTBwriteaddress_o, g.btb_addr); end
      total++;
      if (bus.BTBwritedata_o !== g.btb_data) begin bad++; $display("FAIL %s btb_data got=%h want=%h", tag, bus.BTBwritedata_o, g.btb_data); end
      total++;
      if (bus.PHTwe_o !== g.pht_we) begin bad++; $display("FAIL %s pht_we got=%0b want=%0b", tag, bus.PHTwe_o, g.pht_we); end
      total++;
      if (bus.PHTincrement_o !== g.pht_inc) begin bad++; $display("FAIL %s pht_inc got=%0b want=%0b", tag, bus.PHTincrement_o, g.pht_inc); end
      total++;
      if (bus.PHTwriteaddress_o !== g.pht_addr) begin bad++; $display("FAIL %s pht_addr got=%0d want=%0d", tag, bus.PHTwriteaddress_o, g.pht_addr); end
      if (g.pht_we) exp_bcnt++;
      if (g.mis)    exp_mcnt++;
    end
  endtask

  task automatic check_quiet(input string tag);
    total++;
    if ({bus.Mispredict_e_o, bus.BTB_we_o, bus.PHTwe_o} !== 3'b000)
      begin bad++; $display("FAIL %s quiet got mis/btb/pht=%b want=000", tag, {bus.Mispredict_e_o, bus.BTB_we_o, bus.PHTwe_o}); end
  endtask

  task automatic check_counts(input string tag);
    total++;
    if (bus.BranchCount_o !== 32'(exp_bcnt)) begin bad++; $display("FAIL %s branch_count got=%0d want=%0d", tag, bus.BranchCount_o, exp_bcnt); end
    total++;
    if (bus.MispredictCount_o !== 32'(exp_mcnt)) begin bad++; $display("FAIL %s mispred_count got=%0d want=%0d", tag, bus.MispredictCount_o, exp_mcnt); end
  endtask

  // One instruction through F, D (optionally stalled), E (optionally flushed) and the
  // two cycles after resolution; on a mispredict the younger slots are shown to be squashed.
  task automatic run_one(input string tag, input ins_t b, input exp_t e, input int stall_n, input bit flush);
    drive_f(b.pc, b.pt, b.ptgt, b.pht);
    bus.op_d_i = OP_NOP; bus.BranchActual_e_i = 1'b0; bus.Target_e_i = 32'd0;
    bus.StallD_i = 1'b0; bus.FlushE_i = 1'b0;
    sb.push_back(e);
    tick();
    bus.op_d_i = b.op;
    drive_f(b.pc + 32'd4, 1'b0, 32'd0, 5'd0);
    for (int k = 0; k < stall_n; k++) begin
      bus.StallD_i = 1'b1; bus.BranchActual_e_i = 1'b1; bus.Target_e_i = 32'hdead0000;
      @(negedge clk);
      check_quiet({tag, "_stall"});
      tick();
    end
    bus.StallD_i = 1'b0; bus.BranchActual_e_i = 1'b0; bus.Target_e_i = 32'd0;
    bus.FlushE_i = flush;
    tick();
    bus.FlushE_i = 1'b0;
    bus.op_d_i = e.mis ? OP_BR : OP_NOP;
    drive_f(b.pc + 32'd8, 1'b1, 32'h700, 5'd0);
    bus.BranchActual_e_i = b.act; bus.Target_e_i = b.tgt;
    @(negedge clk);
    check_e(tag, 32'h700);
    tick();
    bus.BranchActual_e_i = 1'b1; bus.Target_e_i = 32'hbad0;
    @(negedge clk);
    check_counts(tag);
    if (e.mis) begin
      check_quiet({tag, "_e_squash"});
      tick();
      @(negedge clk);
      check_quiet({tag, "_d_squash"});
    end
    bus.op_d_i = OP_NOP; bus.BranchActual_e_i = 1'b0; bus.Target_e_i = 32'd0;
    tick();
  endtask

  task automatic test_reset();
    drive_f(32'h100, 1'b0, 32'h0, 5'd0);
    bus.StallF_i = 1'b0; bus.StallD_i = 1'b0; bus.FlushE_i = 1'b0;
    bus.op_d_i = OP_BR; bus.BranchActual_e_i = 1'b1; bus.Target_e_i = 32'h44;
    #1 reset_i = 1'b0;
    #2;
    total++;
    if (bus.PCnext_f_o !== 32'h104) begin bad++; $display("FAIL reset_pcnext got=%h want=%h", bus.PCnext_f_o, 32'h104); end
    check_quiet("reset");
    check_counts("reset");
    total++;
    if (bus.GHRreset_o !== 1'b1) begin bad++; $display("FAIL reset_ghr got=%0b want=1", bus.GHRreset_o); end
    bus.op_d_i = OP_NOP; bus.BranchActual_e_i = 1'b0;
    clk_en = 1'b1;
    tick();
    tick();
    reset_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.GHRreset_o !== 1'b1) begin bad++; $display("FAIL ghr_pulse_first got=%0b want=1", bus.GHRreset_o); end
    tick();
    @(negedge clk);
    total++;
    if (bus.GHRreset_o !== 1'b0) begin bad++; $display("FAIL ghr_pulse_second got=%0b want=0", bus.GHRreset_o); end
    tick();
  endtask

  task automatic test_cold_branch();
    run_one("cold_beq", mk_ins(32'h40, 1'b0, 32'h0, 5'h0A, OP_BR, 1'b1, 32'h80),
            mk_exp(1'b1, 32'h80, 1'b1, 5'd16, 32'h80, 1'b1, 1'b1, 5'h0A), 0, 1'b0);
    run_one("cold_jal", mk_ins(32'h7C, 1'b0, 32'h0, 5'h01, OP_JAL, 1'b1, 32'h10),
            mk_exp(1'b1, 32'h10, 1'b1, 5'd31, 32'h10, 1'b0, 1'b1, 5'h01), 0, 1'b0);
  endtask

  task automatic test_correct_prediction();
    run_one("correct_taken", mk_ins(32'h40, 1'b1, 32'h80, 5'h0B, OP_BR, 1'b1, 32'h80),
            mk_exp(1'b0, 32'h80, 1'b0, 5'd16, 32'h80, 1'b1, 1'b1, 5'h0B), 0, 1'b0);
    run_one("correct_nt", mk_ins(32'h50, 1'b0, 32'h0, 5'h09, OP_BR, 1'b0, 32'h90),
            mk_exp(1'b0, 32'h54, 1'b0, 5'd20, 32'h90, 1'b1, 1'b0, 5'h09), 0, 1'b0);
    run_one("nonbranch", mk_ins(32'h58, 1'b0, 32'h0, 5'h06, OP_NOP, 1'b1, 32'h300),
            mk_exp(1'b0, 32'h300, 1'b0, 5'd22, 32'h300, 1'b0, 1'b1, 5'h06), 0, 1'b0);
  endtask

  task automatic test_wrong_target();
    run_one("jalr_target", mk_ins(32'h60, 1'b1, 32'h100, 5'h03, OP_JALR, 1'b1, 32'h200),
            mk_exp(1'b1, 32'h200, 1'b1, 5'd24, 32'h200, 1'b0, 1'b1, 5'h03), 0, 1'b0);
  endtask

  task automatic test_taken_not_taken();
    run_one("taken_nt", mk_ins(32'h44, 1'b1, 32'h80, 5'h07, OP_BR, 1'b0, 32'h80),
            mk_exp(1'b1, 32'h48, 1'b0, 5'd17, 32'h80, 1'b1, 1'b0, 5'h07), 0, 1'b0);
  endtask

  task automatic test_stall_flush();
    run_one("stall_d", mk_ins(32'h48, 1'b0, 32'h0, 5'h02, OP_BR, 1'b1, 32'hC0),
            mk_exp(1'b1, 32'hC0, 1'b1, 5'd18, 32'hC0, 1'b1, 1'b1, 5'h02), 2, 1'b0);
    run_one("flush_e", mk_ins(32'h4C, 1'b0, 32'h0, 5'h04, OP_BR, 1'b1, 32'hA0),
            mk_exp(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0), 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    ins_t a, b;
    a = mk_ins(32'h40, 1'b1, 32'h80, 5'h0C, OP_BR, 1'b1, 32'h80);
    b = mk_ins(32'h44, 1'b0, 32'h0,  5'h0D, OP_BR, 1'b0, 32'h48);
    drive_f(a.pc, a.pt, a.ptgt, a.pht);
    sb.push_back(mk_exp(1'b0, 32'h80, 1'b0, 5'd16, 32'h80, 1'b1, 1'b1, 5'h0C));
    tick();
    bus.op_d_i = a.op;
    drive_f(b.pc, b.pt, b.ptgt, b.pht);
    sb.push_back(mk_exp(1'b0, 32'h48, 1'b0, 5'd17, 32'h48, 1'b1, 1'b0, 5'h0D));
    tick();
    bus.op_d_i = b.op;
    drive_f(32'h300, 1'b0, 32'h0, 5'd0);
    bus.BranchActual_e_i = a.act; bus.Target_e_i = a.tgt;
    @(negedge clk);
    check_e("b2b_first", 32'h304);
    tick();
    bus.op_d_i = OP_NOP;
    bus.BranchActual_e_i = b.act; bus.Target_e_i = b.tgt;
    @(negedge clk);
    check_e("b2b_second", 32'h304);
    tick();
    bus.BranchActual_e_i = 1'b0;
    @(negedge clk);
    check_counts("b2b");
    tick();
    tick();
  endtask

  task automatic test_async_reset_midop();
    drive_f(32'h40, 1'b0, 32'h0, 5'h0A);
    tick();
    bus.op_d_i = OP_BR;
    drive_f(32'h44, 1'b0, 32'h0, 5'd0);
    tick();
    bus.op_d_i = OP_NOP;
    bus.BranchActual_e_i = 1'b1; bus.Target_e_i = 32'h80;
    @(negedge clk);
    total++;
    if (bus.Mispredict_e_o !== 1'b1) begin bad++; $display("FAIL midop_before got=%0b want=1", bus.Mispredict_e_o); end
    #1 reset_i = 1'b0;
    #1;
    check_quiet("midop_reset");
    total++;
    if (bus.PCnext_f_o !== 32'h48) begin bad++; $display("FAIL midop_pcnext got=%h want=%h", bus.PCnext_f_o, 32'h48); end
    exp_bcnt = 0; exp_mcnt = 0;
    check_counts("midop_reset");
    total++;
    if (bus.GHRreset_o !== 1'b1) begin bad++; $display("FAIL midop_ghr got=%0b want=1", bus.GHRreset_o); end
    #1 reset_i = 1'b1;
    bus.BranchActual_e_i = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (bus.GHRreset_o !== 1'b0) begin bad++; $display("FAIL midop_ghr_clear got=%0b want=0", bus.GHRreset_o); end
  endtask

  initial begin
    test_reset();
    test_cold_branch();
    test_correct_prediction();
    test_wrong_target();
    test_taken_not_taken();
    test_stall_flush();
    test_back_to_back();
    test_async_reset_midop();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_branch_resolve.md
Name: ucsbece154b_branch_resolve

Overview:
- Companion stage to ucsbece154b_branch. It takes the fetch-stage prediction (BranchTaken/BTBtarget/PHT read address) and selects the next fetch PC.
- It carries each prediction through the F->D->E pipeline registers and resolves it in Execute against the actual outcome.
- It drives the predictor's update ports (PHT write, BTB write) and the pipeline redirect/flush on misprediction.
- It keeps branch and mispredict counters for performance measurement.

Parameters:
- NUM_BTB_ENTRIES, 32: BTB depth; BTB index = pc[$clog2(NUM_BTB_ENTRIES)+1:2].
- NUM_GHR_BITS, 5: width of the PHT address carried through the pipeline.

Ports:
- clk  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- pc_f_i  in  32  current fetch PC
- BranchTaken_f_i  in  1  predictor taken prediction for pc_f_i
- BTBtarget_f_i  in  32  predicted target for pc_f_i
- PHTreadaddress_f_i  in  NUM_GHR_BITS  PHT index used for the prediction
- StallF_i  in  1  hold fetch; gates counters only
- StallD_i  in  1  hold D register; insert bubble into E
- FlushE_i  in  1  hazard-unit flush of E register
- op_d_i  in  7  opcode of instruction in Decode
- BranchActual_e_i  in  1  actual taken outcome in Execute (1 for jal/jalr)
- Target_e_i  in  32  actual computed target in Execute
- PCnext_f_o  out  32  next fetch PC
- Mispredict_e_o  out  1  Execute-stage misprediction (redirect and flush)
- BTB_we_o  out  1  BTB write enable
- BTBwriteaddress_o  out  $clog2(NUM_BTB_ENTRIES)  BTB write index
- BTBwritedata_o  out  32  BTB write target
- PHTwe_o  out  1  PHT update enable
- PHTincrement_o  out  1  PHT increment (1) / decrement (0)
- PHTwriteaddress_o  out  NUM_GHR_BITS  PHT index to update
- GHRreset_o  out  1  GHR clear request
- BranchCount_o  out  32  resolved conditional branches
- MispredictCount_o  out  32  mispredicts (branches and jumps)

Behaviour:
- Pipeline registers:
  - D reg holds {valid, pc, pred_taken, pred_target, pht_addr}.
  - E reg holds the same fields plus op.
  - Reset: all valid=0, all fields 0, counters 0.
- D reg, by priority:
  - Mispredict_e_o=1: D.valid<=0.
  - else StallD_i=1: hold.
  - else load from F inputs with valid=1.
- E reg, by priority:
  - Mispredict_e_o=1 or FlushE_i=1 or StallD_i=1: E.valid<=0 (bubble).
  - else load from D, with op<=op_d_i.
- Opcode decode: is_br = op_e==7'b1100011; is_j = op_e==7'b1101111 or 7'b1100111; ctl = E.valid & (is_br|is_j).
- Mispredict_e_o (combinational) = ctl & (BranchActual_e_i != E.pred_taken | (BranchActual_e_i & E.pred_target != Target_e_i)). A not-taken branch predicted not-taken is never a mispredict.
- Redirect PC = BranchActual_e_i ? Target_e_i : E.pc+4.
- PCnext_f_o = Mispredict_e_o ? redirect : (BranchTaken_f_i ? BTBtarget_f_i : pc_f_i+4). Mispredict overrides stall.
- PHT update:
  - PHTwe_o = E.valid & is_br.
  - PHTincrement_o = BranchActual_e_i.
  - PHTwriteaddress_o = E.pht_addr.
- BTB update:
  - BTB_we_o = ctl & BranchActual_e_i & (!E.pred_taken | E.pred_target != Target_e_i).
  - BTBwriteaddress_o = E.pc[$clog2(NUM_BTB_ENTRIES)+1:2].
  - BTBwritedata_o = Target_e_i.
- GHRreset_o: 1 for the first clock edge after reset_i deasserts, 0 otherwise. Implemented as a flop set during reset and cleared on the first clk.
- Counters, both wrap at 2^32 and are cleared only by reset:
  - BranchCount_o += 1 when PHTwe_o.
  - MispredictCount_o += 1 when Mispredict_e_o.
- All update outputs are 0 when E.valid=0. Bubbles and flushed slots never touch the predictor.
- Reset asserted mid-operation clears every register immediately (asynchronous); outputs go to reset values without a clock.

Test Plan:
- Reset: reset_i=0 with no clock -> PCnext_f_o = pc_f_i+4, all *_we/Mispredict = 0, counters = 0. Release -> GHRreset_o=1 for exactly one cycle.
- Cold branch: beq at pc 0x40, predicted not-taken, actual taken to 0x80, reaches E two cycles later -> Mispredict_e_o=1, PCnext_f_o=0x80, BTB_we_o=1, BTBwriteaddress_o=16, BTBwritedata_o=0x80, PHTwe_o=1, PHTincrement_o=1. Next cycle D.valid=0 and E.valid=0.
- Correct prediction: beq predicted taken to 0x80, actual taken to 0x80 -> Mispredict_e_o=0, BTB_we_o=0, PHTwe_o=1. BranchCount_o increments, MispredictCount_o unchanged.
- Wrong target: jalr predicted taken to 0x100, actual target 0x200 -> Mispredict_e_o=1, PCnext_f_o=0x200, BTB_we_o=1, PHTwe_o=0.
- Stall/flush interplay: branch in D with StallD_i=1 for 2 cycles -> E holds a bubble (no PHT/BTB writes), branch resolves once stall drops. Separately, FlushE_i on the branch's E slot -> no update, no count.
- Taken-not-taken: branch predicted taken, actual not-taken at pc 0x44 -> PCnext_f_o=0x48, PHTincrement_o=0, BTB_we_o=0, MispredictCount_o +1.
